// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if
//   Bundles the renderer pixel stream and the framebuffer write port of
//   fb_pixel_writer into one interface.
//   Pixel stream : px_valid, px_ready, px_data[14:0] {B,G,R}, px_sof, px_eol
//   Framebuffer  : fb_busy, fb_addr[ADDR_W-1:0], fb_data[15:0], fb_we
//   Status       : frame_done, err_sync, err_count[7:0]
//   slave  : the writer block (consumes pixels, drives the write port)
//   master : the renderer / framebuffer side (testbench)
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 16
);
    logic              px_valid;
    logic              px_ready;
    logic [14:0]       px_data;
    logic              px_sof;
    logic              px_eol;
    logic              fb_busy;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              fb_we;
    logic              frame_done;
    logic              err_sync;
    logic [7:0]        err_count;

    modport slave (
        input  px_valid, px_data, px_sof, px_eol, fb_busy,
        output px_ready, fb_addr, fb_data, fb_we, frame_done, err_sync, err_count
    );

    modport master (
        output px_valid, px_data, px_sof, px_eol, fb_busy,
        input  px_ready, fb_addr, fb_data, fb_we, frame_done, err_sync, err_count
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Takes the renderer's H_PIXELS x V_LINES BGR555 pixel stream and writes
//   each pixel into the framebuffer at y*H_PIXELS+x. Resynchronises on
//   start-of-frame and end-of-line markers and reports framing errors.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fb_pixel_writer_if.slave (pixel stream in, framebuffer write out,
//          frame_done / err_sync pulses, saturating err_count)
module fb_pixel_writer #(
    parameter int H_PIXELS = 240,
    parameter int V_LINES  = 160,
    parameter int ADDR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    fb_pixel_writer_if.slave   bus
);
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

    localparam logic [7:0]        X_LAST = 8'(H_PIXELS - 1);
    localparam logic [7:0]        Y_LAST = 8'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [ADDR_W-1:0] lb_q, lb_d;     // line base, always y*H_PIXELS
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              xfer;
    logic              take;
    logic              sof_err;
    logic              last_col;
    logic [7:0]        cur_x;
    logic [7:0]        cur_y;
    logic [ADDR_W-1:0] cur_lb;

    assign bus.px_ready = !rst && !bus.fb_busy && (state_q != DONE);
    assign xfer         = bus.px_valid && bus.px_ready;

    assign bus.fb_we      = we_q;
    assign bus.fb_addr    = addr_q;
    assign bus.fb_data    = data_q;
    assign bus.frame_done = done_q;
    assign bus.err_sync   = err_q;
    assign bus.err_count  = cnt_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        lb_d     = lb_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        take     = 1'b0;
        sof_err  = 1'b0;

        // A sof pixel always lands at the frame origin, whatever the tracked
        // position was; everything below works on this effective position.
        cur_x    = bus.px_sof ? 8'd0 : x_q;
        cur_y    = bus.px_sof ? 8'd0 : y_q;
        cur_lb   = bus.px_sof ? '0   : lb_q;
        last_col = (cur_x == X_LAST);

        case (state_q)
            WAIT_SOF: take = xfer && bus.px_sof;
            ACTIVE: begin
                take    = xfer;
                sof_err = bus.px_sof;
            end
            default: state_d = WAIT_SOF;
        endcase

        if (take) begin
            state_d = ACTIVE;
            we_d    = 1'b1;
            addr_d  = cur_lb + ADDR_W'(cur_x);
            data_d  = {1'b0, bus.px_data};
            // eol must coincide with the last column; either mismatch is an error
            err_d   = sof_err || (bus.px_eol != last_col);
            if (bus.px_eol || last_col) begin
                if (cur_y == Y_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                    lb_d    = '0;
                end else begin
                    x_d  = 8'd0;
                    y_d  = cur_y + 8'd1;
                    lb_d = cur_lb + H_STEP;
                end
            end else begin
                x_d  = cur_x + 8'd1;
                y_d  = cur_y;
                lb_d = cur_lb;
            end
            if (err_d && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_SOF;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            lb_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lb_q    <= lb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer
//   Drives directed frame sequences with random pixel data, random px_valid
//   gaps and fb_busy, and compares every cycle of DUT output against a
//   position-based reference model (x, y integers, address = y*240+x).
module tb_fb_pixel_writer;
    localparam int H = 240;
    localparam int V = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_pixel_writer_if #(.ADDR_W(16)) bus ();

    fb_pixel_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int n_done = 0;
    bit rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model + per-cycle checker ----------------
    logic        c_rst, c_v, c_rdy, c_sof, c_eol, c_busy;
    logic [14:0] c_d;
    int          m_x = 0, m_y = 0, e_cnt = 0;
    bit          m_act = 1'b0, m_done = 1'b0;
    logic [15:0] e_addr = 16'd0, e_data = 16'd0;
    bit          e_we, e_done, e_err, e_rdy, xf, bad;

    always begin
        @(negedge clk);
        #2;
        c_rst  = rst;
        c_v    = bus.px_valid;
        c_rdy  = bus.px_ready;
        c_d    = bus.px_data;
        c_sof  = bus.px_sof;
        c_eol  = bus.px_eol;
        c_busy = bus.fb_busy;
        @(posedge clk);
        #1;
        e_we   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_rdy  = !c_rst && !c_busy && !m_done;
        if (c_rst) begin
            m_act = 1'b0; m_done = 1'b0; m_x = 0; m_y = 0;
            e_addr = 16'd0; e_data = 16'd0; e_cnt = 0;
        end else begin
            xf     = c_v && e_rdy;
            m_done = 1'b0;
            if (xf) begin
                bad = 1'b0;
                if (c_sof) begin
                    bad   = m_act;
                    m_act = 1'b1;
                    m_x   = 0;
                    m_y   = 0;
                end
                if (m_act) begin
                    e_we   = 1'b1;
                    e_addr = 16'(m_y * H + m_x);
                    e_data = {1'b0, c_d};
                    if (c_eol != (m_x == H - 1)) bad = 1'b1;
                    if (c_eol || (m_x == H - 1)) begin
                        m_x = 0;
                        m_y++;
                        if (m_y == V) begin
                            m_y = 0; m_act = 1'b0; m_done = 1'b1; e_done = 1'b1;
                        end
                    end else begin
                        m_x++;
                    end
                    if (bad) begin
                        e_err = 1'b1;
                        if (e_cnt < 255) e_cnt++;
                    end
                end
            end
        end
        chk("px_ready",   32'(c_rdy),          32'(e_rdy));
        chk("fb_we",      32'(bus.fb_we),      32'(e_we));
        chk("fb_addr",    32'(bus.fb_addr),    32'(e_addr));
        chk("fb_data",    32'(bus.fb_data),    32'(e_data));
        chk("err_sync",   32'(bus.err_sync),   32'(e_err));
        chk("frame_done", 32'(bus.frame_done), 32'(e_done));
        chk("err_count",  32'(bus.err_count),  32'(e_cnt));
        if (bus.fb_we === 1'b1) n_wr++;
        if (bus.frame_done === 1'b1) n_done++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic sof, input logic eol);
        int  t;
        bit  r;
        if (rnd_mode && ($urandom_range(31) == 0)) begin
            bus.px_valid = 1'b0;
            bus.fb_busy  = 1'b0;
            @(negedge clk);
        end
        bus.px_valid = 1'b1;
        bus.px_data  = 15'($urandom_range(32767));
        bus.px_sof   = sof;
        bus.px_eol   = eol;
        t = 0;
        forever begin
            bus.fb_busy = rnd_mode ? ($urandom_range(31) == 0) : 1'b0;
            #1;
            r = bus.px_ready;
            @(posedge clk);
            if (r) break;
            t++;
            if (t > 200) begin
                $display("FAIL send_timeout observed=ready_low expected=transfer_within_200");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.px_valid = 1'b0;
        bus.fb_busy  = 1'b0;
    endtask

    task automatic line(input int n, input bit eol_last);
        for (int i = 0; i < n; i++) send(1'b0, eol_last && (i == n - 1));
    endtask

    task automatic idle(input int k);
        bus.px_valid = 1'b0;
        bus.fb_busy  = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.px_valid = 1'b0;
        bus.px_data  = 15'd0;
        bus.px_sof   = 1'b0;
        bus.px_eol   = 1'b0;
        bus.fb_busy  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);
        chk("rst_we",    32'(bus.fb_we),     32'd0);
        chk("rst_count", 32'(bus.err_count), 32'd0);

        // pixels before any sof are dropped, then a clean frame with gaps/busy
        n_wr = 0;
        line(100, 1'b0);
        idle(3);
        chk("no_sof_writes", 32'(n_wr), 32'd0);
        rnd_mode = 1'b1;
        for (int i = 0; i < H * V; i++) send(i == 0, (i % H) == H - 1);
        rnd_mode = 1'b0;
        idle(4);
        chk("clean_writes", 32'(n_wr),          32'(H * V));
        chk("clean_done",   32'(n_done),        32'd1);
        chk("clean_errs",   32'(bus.err_count), 32'd0);

        // framing errors: missing eol, early eol, mid-frame sof
        n_wr = 0; n_done = 0;
        send(1'b1, 1'b0);
        line(240, 1'b0);
        idle(3);
        chk("missing_eol_cnt", 32'(bus.err_count), 32'd1);
        line(239, 1'b1);
        for (int l = 2; l < 5; l++) line(240, 1'b1);
        line(101, 1'b1);
        idle(3);
        chk("early_eol_cnt", 32'(bus.err_count), 32'd2);
        for (int l = 6; l < 10; l++) line(240, 1'b1);
        line(17, 1'b0);
        send(1'b1, 1'b0);
        idle(3);
        chk("mid_sof_cnt", 32'(bus.err_count), 32'd3);
        line(239, 1'b1);
        for (int l = 1; l < V - 1; l++) line(240, 1'b1);
        idle(3);
        chk("no_early_done", 32'(n_done), 32'd0);
        line(240, 1'b1);
        idle(4);
        chk("err_frame_done", 32'(n_done),        32'd1);
        chk("err_frame_cnt",  32'(bus.err_count), 32'd3);

        // reset mid-frame abandons the frame
        send(1'b1, 1'b0);
        for (int l = 0; l < 2; l++) line(240, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_we",   32'(bus.fb_we),      32'd0);
        chk("mrst_addr", 32'(bus.fb_addr),    32'd0);
        chk("mrst_data", 32'(bus.fb_data),    32'd0);
        chk("mrst_cnt",  32'(bus.err_count),  32'd0);
        chk("mrst_done", 32'(bus.frame_done), 32'd0);
        chk("mrst_err",  32'(bus.err_sync),   32'd0);
        n_wr = 0;
        line(20, 1'b0);
        idle(3);
        chk("post_rst_writes", 32'(n_wr), 32'd0);

        // repeated sof+eol: each transfer is one error, counter saturates
        for (int i = 0; i < 260; i++) send(1'b1, 1'b1);
        idle(3);
        chk("sat_writes", 32'(n_wr),          32'd260);
        chk("sat_count",  32'(bus.err_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
